pc_fetch_unit: RTL
==================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 12'h000, byte address of the first fetch after reset.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: npc  input  12  redirect target byte address from the next-PC generator.
REQ-005 Port: redirect  input  1  npc is a non-sequential target (taken branch, jump, jump-register); single-cycle qualifier.
REQ-006 Port: stall  input  1  ID stage cannot accept a new instruction this cycle.
REQ-007 Port: imem_ready  input  1  instruction memory returns imem_rdata for the outstanding request this cycle.
REQ-008 Port: imem_rdata  input  32  instruction word.
REQ-009 Port: imem_req  output  1  fetch request valid.
REQ-010 Port: imem_addr  output  12  fetch byte address, registered.
REQ-011 Port: if_valid  output  1  IF/ID register holds a live instruction.
REQ-012 Port: if_instr  output  32  IF/ID instruction.
REQ-013 Port: if_pc_4  output  12  IF/ID fetch address + 4, for the next-PC generator and the link path.

Function
REQ-014 Block SHALL keep a 12-bit fetch pointer pc; pc + 4 SHALL wrap modulo 4096 (12'hFFC + 4 = 12'h000).
REQ-015 States SHALL be FETCH (request outstanding), HOLD (word captured, ID stalled), DROP (outstanding word to be discarded).
REQ-016 In FETCH and DROP, imem_req SHALL be 1 and imem_addr SHALL stay constant until the cycle imem_ready=1; in HOLD, imem_req SHALL be 0.
REQ-017 FETCH, imem_ready=1, redirect=0, stall=0: IF/ID SHALL load {imem_rdata, imem_addr+4} with if_valid=1; pc and imem_addr SHALL advance to imem_addr+4; state stays FETCH (one word per cycle when memory is zero-wait).
REQ-018 FETCH, imem_ready=1, redirect=0, stall=1: word SHALL go into a 32-bit hold buffer; IF/ID SHALL keep its contents; next state HOLD.
REQ-019 HOLD, stall=0, redirect=0: IF/ID SHALL load the buffered word with if_valid=1; imem_addr SHALL advance by 4; next state FETCH.
REQ-020 FETCH, imem_ready=0, stall=0: if_valid SHALL go to 0 next cycle (bubble); with stall=1, IF/ID SHALL hold.
REQ-021 redirect=1 SHALL take priority over stall and imem_ready: pc <= npc, if_valid <= 0 next cycle, returning or buffered data discarded.
REQ-022 Redirect while in FETCH with imem_ready=0 SHALL move to DROP; imem_addr SHALL hold the old address.
REQ-023 Redirect while in FETCH with imem_ready=1, or while in HOLD: imem_addr <= npc; next state FETCH.
REQ-024 DROP, imem_ready=1: data SHALL be discarded and imem_addr <= pc; next state FETCH; a further redirect in DROP SHALL only overwrite pc.
REQ-025 While stall=1 and redirect=0, if_instr, if_pc_4 and if_valid SHALL NOT change.
REQ-026 No instruction SHALL be delivered twice or skipped; delivery order SHALL equal address order between redirects.

Reset
REQ-027 While rst=1: state FETCH, pc = imem_addr = RESET_PC, imem_req = 0, if_valid = 0, if_instr = 32'h0 (nop), if_pc_4 = 12'h0, hold buffer cleared.
REQ-028 First cycle after rst falls: imem_req = 1 with imem_addr = RESET_PC.
REQ-029 rst during HOLD or DROP SHALL abandon the pending word; a late imem_ready after reset SHALL be treated as the response to the RESET_PC request.

Verification
REQ-030 Zero-wait memory, no stall, 4 cycles -> if_instr words from 0x000/0x004/0x008/0x00C, if_pc_4 = 0x004/0x008/0x00C/0x010, if_valid continuous.
REQ-031 stall=1 for 3 cycles while word at 0x010 returns -> imem_req=0 in HOLD, IF/ID unchanged; on release IF/ID = word@0x010, if_pc_4 = 0x014, next request 0x014.
REQ-032 Request 0x020 outstanding, imem_ready delayed 2 cycles, redirect with npc=0x100 on first wait cycle -> imem_addr holds 0x020 until ready, data dropped, next imem_addr = 0x100, if_valid=0 throughout.
REQ-033 redirect and stall together in HOLD, npc=0x040 -> buffer discarded, if_valid=0, imem_addr=0x040, state FETCH.
REQ-034 RESET_PC=12'hFFC, zero-wait -> second fetch address 0x000, first if_pc_4 = 0x000.
REQ-035 rst asserted in DROP -> all outputs at reset values next cycle; after release first delivered word is from RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: owns the fetch pointer, talks to a variable-latency
// instruction memory and feeds the IF/ID register, absorbing stalls and redirects.
module pc_fetch_unit #(
    parameter logic [11:0] RESET_PC = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] npc,
    input  logic        redirect,
    input  logic        stall,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [11:0] imem_addr,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [11:0] if_pc_4
);

    typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DROP} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [11:0] r_pc;
    logic [11:0] r_addr;
    logic [31:0] r_hold_buf;
    logic        r_if_valid;
    logic [31:0] r_if_instr;
    logic [11:0] r_if_pc_4;
    logic [11:0] w_addr_p4;
    logic        w_req;
    logic        w_deliver_mem;
    logic        w_deliver_buf;
    logic        w_capture;
    logic        w_bubble;

    // 12-bit add wraps naturally modulo 4096
    assign w_addr_p4 = r_addr + 12'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (redirect) begin
                    w_state_next = imem_ready ? S_FETCH : S_DROP;
                end else if (imem_ready && stall) begin
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect || !stall) begin
                    w_state_next = S_FETCH;
                end
            end
            S_DROP: begin
                if (imem_ready) begin
                    w_state_next = S_FETCH;
                end
            end
            default: w_state_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_req         = !rst && (r_state != S_HOLD);
        w_deliver_mem = (r_state == S_FETCH) && imem_ready && !redirect && !stall;
        w_deliver_buf = (r_state == S_HOLD) && !redirect && !stall;
        w_capture     = (r_state == S_FETCH) && imem_ready && !redirect && stall;
        w_bubble      = redirect || ((r_state == S_FETCH) && !imem_ready && !stall);
    end

    // IF/ID register and hold buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_valid <= 1'b0;
            r_if_instr <= 32'h0;
            r_if_pc_4  <= 12'h0;
            r_hold_buf <= 32'h0;
        end else begin
            if (w_deliver_mem) begin
                r_if_valid <= 1'b1;
                r_if_instr <= imem_rdata;
                r_if_pc_4  <= w_addr_p4;
            end else if (w_deliver_buf) begin
                r_if_valid <= 1'b1;
                r_if_instr <= r_hold_buf;
                r_if_pc_4  <= w_addr_p4;
            end else if (w_bubble) begin
                r_if_valid <= 1'b0;
            end
            if (w_capture) begin
                r_hold_buf <= imem_rdata;
            end
        end
    end

    // In DROP the request address stays on the abandoned fetch while pc tracks the target
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc   <= RESET_PC;
            r_addr <= RESET_PC;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (redirect) begin
                        r_pc <= npc;
                        if (imem_ready) begin
                            r_addr <= npc;
                        end
                    end else if (imem_ready && !stall) begin
                        r_pc   <= w_addr_p4;
                        r_addr <= w_addr_p4;
                    end
                end
                S_HOLD: begin
                    if (redirect) begin
                        r_pc   <= npc;
                        r_addr <= npc;
                    end else if (!stall) begin
                        r_pc   <= w_addr_p4;
                        r_addr <= w_addr_p4;
                    end
                end
                S_DROP: begin
                    if (redirect) begin
                        r_pc <= npc;
                    end
                    if (imem_ready) begin
                        r_addr <= redirect ? npc : r_pc;
                    end
                end
                default: begin
                    r_pc   <= r_pc;
                    r_addr <= r_addr;
                end
            endcase
        end
    end

    assign imem_req  = w_req;
    assign imem_addr = r_addr;
    assign if_valid  = r_if_valid;
    assign if_instr  = r_if_instr;
    assign if_pc_4   = r_if_pc_4;

endmodule
